serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder controller. It time-shares one full-adder cell, built from two existing half_adder instances, across all operand bits. One bit is processed per clock, LSB first, under a start/busy/done handshake. It is the sequencing layer that turns the combinational half_adder primitive into a multi-bit arithmetic unit for small-area datapaths.

---
 rtl/serial_add_ctrl_pkg.sv | 11 +
 rtl/fa_cell.sv | 17 +
 rtl/half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding for the bit-serial adder controller
package serial_add_ctrl_pkg;

  // Encoding 2'd3 is unused and is steered back to IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - full-adder cell built from two half adders and an OR of their carries
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - combinational half adder primitive
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_s, fa_c;
  logic               last_bit;

  fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) cout_d = fa_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=3
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start8, start3;
  logic [7:0] a8, b8, sum8;
  logic [2:0] a3, b3, sum3;
  logic       busy8, done8, cout8;
  logic       busy3, done3, cout3;

  logic [8:0] q8[$];
  logic [3:0] q3[$];

  int checks;
  int fails;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge while IDLE; returns at the negedge right after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
    start8 = 1'b1; a8 = av; b8 = bv;
    q8.push_back({1'b0, av} + {1'b0, bv});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue3(input logic [2:0] av, input logic [2:0] bv);
    start3 = 1'b1; a3 = av; b3 = bv;
    q3.push_back({1'b0, av} + {1'b0, bv});
    @(negedge clk);
    start3 = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; returns one cycle after done.
  task automatic wait8(output logic [7:0] s, output logic c, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (1) begin
      if (busy8 === 1'b1) bcnt++;
      if (done8 === 1'b1) break;
      if (lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    s = sum8; c = cout8;
    checks++;
    if (done8 !== 1'b1) begin
      fails++;
      $display("FAIL wait8_done_timeout got=%b exp=1 after %0d edges", done8, lat);
    end
    @(negedge clk);
  endtask

  task automatic wait3(output logic [2:0] s, output logic c, output int lat);
    lat = 0;
    while (1) begin
      if (done3 === 1'b1) break;
      if (lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    s = sum3; c = cout3;
    checks++;
    if (done3 !== 1'b1) begin
      fails++;
      $display("FAIL wait3_done_timeout got=%b exp=1 after %0d edges", done3, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", done8); end
    checks++; if (sum8 !== 8'h00) begin fails++; $display("FAIL rst_sum got=%h exp=00", sum8); end
    checks++; if (cout8 !== 1'b0) begin fails++; $display("FAIL rst_cout got=%b exp=0", cout8); end
    checks++; if ({busy3, done3, sum3, cout3} !== 6'b0) begin
      fails++; $display("FAIL rst_w3 got=%b exp=000000", {busy3, done3, sum3, cout3});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc;
    issue8(8'h5A, 8'h3C);
    wait8(s, c, lat, bc);
    e = q8.pop_front();
    checks++; if (s !== 8'h96 || s !== e[7:0]) begin fails++; $display("FAIL basic_sum got=%h exp=96", s); end
    checks++; if (c !== 1'b0) begin fails++; $display("FAIL basic_cout got=%b exp=0", c); end
    checks++; if (lat + 1 != 9) begin fails++; $display("FAIL basic_latency got=%0d exp=9", lat + 1); end
    checks++; if (bc != 9) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL basic_after_done got=%b%b exp=00", busy8, done8);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ta[3] = '{8'hFF, 8'h80, 8'h00};
    logic [7:0] tb[3] = '{8'h01, 8'h80, 8'h00};
    logic [8:0] te[3] = '{9'h100, 9'h100, 9'h000};
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      issue8(ta[i], tb[i]);
      wait8(s, c, lat, bc);
      e = q8.pop_front();
      checks++;
      if ({c, s} !== e || e !== te[i]) begin
        fails++; $display("FAIL corner%0d got=%h exp=%h", i, {c, s}, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    q8.push_back(9'h046);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    q8.push_back(9'h1FE);
    wait8(s, c, lat, bc);
    e = q8.pop_front();
    checks++; if ({c, s} !== e) begin fails++; $display("FAIL b2b_first got=%h exp=%h", {c, s}, e); end
    checks++; if (busy8 !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got=%b exp=0", busy8); end
    @(negedge clk);
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin fails++; $display("FAIL b2b_retrigger got=%b exp=1", busy8); end
    wait8(s, c, lat, bc);
    e = q8.pop_front();
    checks++; if ({c, s} !== e) begin fails++; $display("FAIL b2b_second got=%h exp=%h", {c, s}, e); end
    checks++; if (lat + 1 != 9) begin fails++; $display("FAIL b2b_latency got=%0d exp=9", lat + 1); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc, seen;
    issue8(8'hAA, 8'h55);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL midrst_ctrl got=%b%b exp=00", busy8, done8);
    end
    checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      fails++; $display("FAIL midrst_result got=%h/%b exp=00/0", sum8, cout8);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    issue8(8'h01, 8'h02);
    wait8(s, c, lat, bc);
    e = q8.pop_front();
    checks++; if ({c, s} !== 9'h003 || {c, s} !== e) begin
      fails++; $display("FAIL midrst_next got=%h exp=003", {c, s});
    end
  endtask

  task automatic test_done_hold();
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc, dn;
    issue8(8'h0F, 8'h01);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    wait8(s, c, lat, bc);
    e = q8.pop_front();
    checks++; if ({c, s} !== e) begin fails++; $display("FAIL hold_ignore_start got=%h exp=%h", {c, s}, e); end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done8 === 1'b1) dn++;
      checks++;
      if (busy8 !== 1'b0 || {cout8, sum8} !== e) begin
        fails++; $display("FAIL hold_idle%0d got=%b/%h exp=0/%h", i, busy8, {cout8, sum8}, e);
      end
      @(negedge clk);
    end
    checks++; if (dn != 0) begin fails++; $display("FAIL hold_done_once got=%0d exp=0", dn); end
  endtask

  task automatic test_random();
    logic [7:0] s; logic c; logic [8:0] e; int lat, bc;
    logic [2:0] s3; logic c3; logic [3:0] e3;
    for (int i = 0; i < 200; i++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait8(s, c, lat, bc);
      e = q8.pop_front();
      checks++;
      if ({c, s} !== e || lat + 1 != 9) begin
        fails++; $display("FAIL rand8_%0d got=%h lat=%0d exp=%h lat=9", i, {c, s}, lat + 1, e);
      end
    end
    for (int i = 0; i < 200; i++) begin
      issue3(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      wait3(s3, c3, lat);
      e3 = q3.pop_front();
      checks++;
      if ({c3, s3} !== e3 || lat + 1 != 4) begin
        fails++; $display("FAIL rand3_%0d got=%h lat=%0d exp=%h lat=4", i, {c3, s3}, lat + 1, e3);
      end
    end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid_run();
    test_done_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
